// File: rtl/svm_pkg.sv
// Shared constants and helpers for the stage-1 SVM decision function.
// Widths derive from the pixel width; the kernel mux uses kern_lsb.
package svm_pkg;

    localparam int XLEN_PIXEL = 8;
    localparam int NUM_OF_SV  = 87;
    localparam int KERN_W     = 5 * XLEN_PIXEL;
    localparam int COEF_W     = 2 * XLEN_PIXEL;
    localparam int MUL_W      = COEF_W + KERN_W + 1;
    localparam int ACC_W      = 64;

    function automatic int kern_lsb(input int c);
        return c * KERN_W;
    endfunction

endpackage

// File: rtl/svm_coef_mac.sv
// Registered signed coefficient x unsigned kernel multiply, then accumulate.
// The first term of a classification overwrites the accumulator.
module svm_coef_mac
    import svm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_first,
    input  logic [COEF_W-1:0] i_coef,
    input  logic [KERN_W-1:0] i_kern,
    output logic [ACC_W-1:0]  o_acc
);

    logic signed [MUL_W-1:0] w_prod;
    logic signed [MUL_W-1:0] r_mul;
    logic                    r_mul_v;
    logic                    r_first;
    logic [ACC_W-1:0]        w_ext;

    // Zero-extend the kernel so it stays non-negative in the signed product.
    assign w_prod = $signed(i_coef) * $signed({1'b0, i_kern});
    assign w_ext  = {{(ACC_W-MUL_W){r_mul[MUL_W-1]}}, r_mul};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mul   <= '0;
            r_mul_v <= 1'b0;
            r_first <= 1'b0;
            o_acc   <= '0;
        end else begin
            r_mul_v <= i_load;
            if (i_load) begin
                r_mul   <= w_prod;
                r_first <= i_first;
            end
            if (r_mul_v) begin
                o_acc <= r_first ? w_ext : o_acc + w_ext;
            end
        end
    end

endmodule

// File: rtl/svm_decision_funct.sv
// Stage-1 SVM decision: sum of alpha*y*kernel terms plus bias, class = sign.
// Index counter, kernel mux and completion logic around svm_coef_mac.
module svm_decision_funct
    import svm_pkg::*;
#(
    parameter int P_NUM_SV = svm_pkg::NUM_OF_SV
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [KERN_W*P_NUM_SV-1:0] i_kernel_out,
    input  logic                       i_decision_funct_en,
    input  logic [COEF_W-1:0]          i_product,
    input  logic [COEF_W-1:0]          i_b,
    output logic                       o_y_class,
    output logic                       o_y_valid
);

    localparam int IDX_W = $clog2(P_NUM_SV + 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(P_NUM_SV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_NUM_SV - 1);

    logic [IDX_W-1:0]  r_idx;
    logic              r_done;
    logic              r_last_mul;
    logic              r_last_acc;
    logic              w_accept;
    logic              w_first;
    logic [KERN_W-1:0] w_kern;
    logic [ACC_W-1:0]  w_acc;
    logic [ACC_W-1:0]  w_f;

    assign w_accept = i_decision_funct_en && (r_idx < IDX_END) && !r_done;
    assign w_first  = (r_idx == '0);

    always_comb begin
        w_kern = '0;
        for (int c = 0; c < P_NUM_SV; c++) begin
            if (r_idx == IDX_W'(c)) begin
                w_kern = i_kernel_out[kern_lsb(c) +: KERN_W];
            end
        end
    end

    svm_coef_mac u_mac (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_accept),
        .i_first (w_first),
        .i_coef  (i_product),
        .i_kern  (w_kern),
        .o_acc   (w_acc)
    );

    assign w_f = w_acc + {{(ACC_W-COEF_W){i_b[COEF_W-1]}}, i_b};

    // r_last_* follow the final term through the multiply and add stages.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_last_mul <= 1'b0;
            r_last_acc <= 1'b0;
            o_y_class  <= 1'b0;
            o_y_valid  <= 1'b0;
        end else begin
            r_last_mul <= w_accept && (r_idx == IDX_LAST);
            r_last_acc <= r_last_mul;
            o_y_valid  <= r_last_acc;
            if (r_last_acc) begin
                o_y_class <= ~w_f[ACC_W-1];
            end
            if (!i_decision_funct_en) begin
                r_idx  <= '0;
                r_done <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
                if (r_last_acc) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_svm_decision_funct.sv
// Directed bench for svm_decision_funct with four support vectors.
// A plain-arithmetic model predicts f, the class and the y_valid cycle.
module tb_svm_decision_funct;

    localparam int NSV = 4;
    localparam int KW  = 40;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [KW*NSV-1:0] kern = '0;
    logic              en = 1'b0;
    logic [CW-1:0]     prod = '0;
    logic [CW-1:0]     bias = '0;
    logic              y_class;
    logic              y_valid;

    svm_decision_funct #(.P_NUM_SV(NSV)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_kernel_out        (kern),
        .i_decision_funct_en (en),
        .i_product           (prod),
        .i_b                 (bias),
        .o_y_class           (y_class),
        .o_y_valid           (y_valid)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     rst_cyc = -10;
    int     exp_valid_cyc = -1;
    bit     exp_class_next = 1'b0;
    bit     exp_class = 1'b0;
    bit     chk_on = 1'b0;
    int     pulses = 0;
    longint last_f = 0;
    longint kv[NSV];
    longint pv[NSV];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model and per-cycle compare: a valid pulse is due two edges after the
    // last term unless a reset edge landed after that term.
    always begin
        bit exp_v;
        @(posedge clk);
        cyc++;
        if (rst) begin
            rst_cyc = cyc;
            exp_class = 1'b0;
        end
        @(negedge clk);
        exp_v = (cyc == exp_valid_cyc) && (rst_cyc < exp_valid_cyc - 1);
        if (exp_v) exp_class = exp_class_next;
        if (chk_on) begin
            check("y_valid", longint'(y_valid), longint'(exp_v));
            check("y_class", longint'(y_class), longint'(exp_class));
            if (y_valid) pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_stream(input int nterms, input int tail_en, input longint bval);
        longint f;
        int     last_edge;
        for (int c = 0; c < NSV; c++) kern[c*KW +: KW] = kv[c][KW-1:0];
        bias = bval[CW-1:0];
        f = bval;
        last_edge = cyc;
        for (int t = 0; t < nterms; t++) begin
            en   = 1'b1;
            prod = pv[t][CW-1:0];
            tick();
            f += pv[t] * kv[t];
            last_edge = cyc;
        end
        if (nterms == NSV) begin
            last_f         = f;
            exp_class_next = (f >= 0);
            exp_valid_cyc  = last_edge + 2;
        end
        repeat (tail_en) tick();
        en   = 1'b0;
        prod = '0;
        repeat (4) tick();
    endtask

    task automatic set_k(input longint a, input longint b2, input longint c, input longint d);
        kv[0] = a; kv[1] = b2; kv[2] = c; kv[3] = d;
    endtask

    task automatic set_p(input longint a, input longint b2, input longint c, input longint d);
        pv[0] = a; pv[1] = b2; pv[2] = c; pv[3] = d;
    endtask

    initial begin
        int p0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_y_class", longint'(y_class), 0);
        check("reset_y_valid", longint'(y_valid), 0);
        chk_on = 1'b1;
        tick();

        // Case 1: f = 10+20+30+40 = 100
        set_k(10, 20, 30, 40); set_p(1, 1, 1, 1);
        p0 = pulses;
        do_stream(4, 0, 0);
        check("c1_f", last_f, 100);
        check("c1_class", longint'(y_class), 1);
        check("c1_pulses", longint'(pulses - p0), 1);

        // Case 2: f = -100 + 5 = -95
        set_p(-1, -1, -1, -1);
        p0 = pulses;
        do_stream(4, 0, 5);
        check("c2_f", last_f, -95);
        check("c2_class", longint'(y_class), 0);
        check("c2_pulses", longint'(pulses - p0), 1);

        // Case 3: zero boundary, then one below
        set_k(1, 0, 0, 0); set_p(5, 5, 5, 5);
        do_stream(4, 0, -5);
        check("c3a_f", last_f, 0);
        check("c3a_class", longint'(y_class), 1);
        do_stream(4, 0, -6);
        check("c3b_f", last_f, -1);
        check("c3b_class", longint'(y_class), 0);

        // Case 4: extreme magnitudes
        set_k(67108863, 67108863, 67108863, 67108863);
        set_p(-32767, -32767, -32767, -32767);
        do_stream(4, 0, -32767);
        check("c4_f", last_f, -64'sd8795824488451);
        check("c4_class", longint'(y_class), 0);

        // Case 5: aborted partial stream, then a clean case-1 stream
        set_k(10, 20, 30, 40); set_p(-100, -100, 1, 1);
        p0 = pulses;
        do_stream(2, 0, 0);
        check("c5_abort_pulses", longint'(pulses - p0), 0);
        set_p(1, 1, 1, 1);
        do_stream(4, 0, 0);
        check("c5_class", longint'(y_class), 1);
        check("c5_pulses", longint'(pulses - p0), 1);

        // Case 6: reset mid-stream, then a full stream with en held high
        set_p(-1, -1, -1, -1);
        p0 = pulses;
        en = 1'b1;
        prod = 16'hFFFF;
        tick();
        tick();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("c6_rst_class", longint'(y_class), 0);
        check("c6_rst_pulses", longint'(pulses - p0), 0);
        set_p(1, 1, 1, 1);
        p0 = pulses;
        do_stream(4, 8, 0);
        check("c6_class", longint'(y_class), 1);
        check("c6_pulses", longint'(pulses - p0), 1);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
